// File: rtl/sub32_pipe.sv
// sub32_pipe: two-stage pipelined WIDTH-bit subtractor (A + ~B + 1) with valid/ready flow control
// and borrow, signed-overflow and zero flags; each half uses a parallel-prefix carry network.
module sub32_cla #(parameter int W = 16) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  // Kogge-Stone prefix: bit i+1 of the result is the carry out of bits [i:0]
  function automatic logic [W:0] carries(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W-1:0] g, p, gn, pn;
    g = x & y;
    p = x ^ y;
    for (int d = 1; d < W; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < W; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    return {g | (p & {W{ci}}), ci};
  endfunction
  logic [W:0] c;
  assign c    = carries(a, b, cin);
  assign s    = a ^ b ^ c[W-1:0];
  assign cout = c[W];
endmodule

module sub32_pipe #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:1]   A,
  input  logic [WIDTH:1]   B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:1]   D,
  output logic             BOUT,
  output logic             OVF,
  output logic             ZERO
);
  localparam int HALF = WIDTH / 2;
  logic            s1_valid, s2_valid, c_half, c_lo, c_out;
  logic            s2_can_accept, s1_fwd, load;
  logic [HALF-1:0] d_lo, a_hi, b_hi, sum_lo, sum_hi;
  assign s2_can_accept = ~s2_valid | out_ready;
  assign s1_fwd        = s1_valid & s2_can_accept;
  assign in_ready      = ~s1_valid | s2_can_accept;
  assign load          = in_valid & in_ready;
  assign out_valid     = s2_valid;
  sub32_cla #(.W(HALF)) u_lo (.a(A[HALF:1]), .b(~B[HALF:1]), .cin(1'b1), .s(sum_lo), .cout(c_lo));
  sub32_cla #(.W(HALF)) u_hi (.a(a_hi), .b(~b_hi), .cin(c_half), .s(sum_hi), .cout(c_out));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      d_lo     <= '0;
      c_half   <= 1'b0;
      a_hi     <= '0;
      b_hi     <= '0;
      D        <= '0;
      BOUT     <= 1'b0;
      OVF      <= 1'b0;
      ZERO     <= 1'b0;
    end else begin
      if (load) begin
        s1_valid <= 1'b1;
        d_lo     <= sum_lo;
        c_half   <= c_lo;
        a_hi     <= A[WIDTH:HALF+1];
        b_hi     <= B[WIDTH:HALF+1];
      end else if (s1_fwd) s1_valid <= 1'b0;
      if (s1_fwd) begin
        s2_valid <= 1'b1;
        D        <= {sum_hi, d_lo};
        BOUT     <= ~c_out;
        OVF      <= (a_hi[HALF-1] ^ b_hi[HALF-1]) & (sum_hi[HALF-1] ^ a_hi[HALF-1]);
        ZERO     <= ~|{sum_hi, d_lo};
      end else if (out_ready) s2_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sub32_pipe.sv
// tb_sub32_pipe: directed and randomized checks of sub32_pipe results, flags, latency, stall and reset.
module tb_sub32_pipe;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid, bout, ovf, zero;
  logic [31:0] a = 0, b = 0, d;
  int          checks = 0, errors = 0;

  sub32_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .out_valid(out_valid), .out_ready(out_ready), .D(d), .BOUT(bout), .OVF(ovf), .ZERO(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    r = x - y;
    return {x < y, (x[31] != y[31]) && (r[31] != x[31]), r == 0, r};
  endfunction

  task test_reset;
    #1;
    checks++;
    if ({out_valid, d, bout, ovf, zero} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ov=%b d=%h f=%b%b%b expected all zero", out_valid, d, bout, ovf, zero);
    end
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task test_arith;
    logic [31:0] va [8] = '{32'd5, 32'd3, 32'h12345678, 32'h00010000, 32'h80000000, 32'h0, 32'h7FFFFFFF, 32'hFFFF0000};
    logic [31:0] vb [8] = '{32'd3, 32'd5, 32'h12345678, 32'h1, 32'h1, 32'h80000000, 32'hFFFFFFFF, 32'h0000FFFF};
    logic [34:0] ve [8] = '{{3'b000, 32'h00000002}, {3'b100, 32'hFFFFFFFE}, {3'b001, 32'h0},
                           {3'b000, 32'h0000FFFF}, {3'b010, 32'h7FFFFFFF}, {3'b110, 32'h80000000},
                           {3'b110, 32'h80000000}, {3'b000, 32'hFFFE0001}};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = va[i];
      b = vb[i];
      in_valid = 1;
      out_ready = 1;
      @(negedge clk);
      in_valid = 0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL arith_latency[%0d]: got out_valid=%b expected 0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || {bout, ovf, zero, d} !== ve[i]) begin
        errors++;
        $display("FAIL arith[%0d]: got ov=%b %h expected ov=1 %h", i, out_valid, {bout, ovf, zero, d}, ve[i]);
      end
    end
  endtask

  task test_stream;
    logic [31:0] sa [6] = '{32'h1, 32'h0000FFFF, 32'hDEADBEEF, 32'h00020000, 32'h7FFFFFFF, 32'hAAAA5555};
    logic [31:0] sb [6] = '{32'h2, 32'h0000FFFF, 32'h0000BEEF, 32'h00000001, 32'h80000000, 32'h5555AAAA};
    logic [34:0] q [$];
    logic [31:0] d_hold;
    int k = 0, got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 6);
      in_valid = k < 6;
      a = (k < 6) ? sa[k] : 32'h0;
      b = (k < 6) ? sb[k] : 32'h0;
      #1;
      if (c >= 2 && c <= 6) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stream_valid c%0d: got %b expected 1", c, out_valid);
        end
      end
      if (c >= 4 && c <= 6) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready c%0d: got %b expected 0", c, in_ready);
        end
      end
      if (c == 4) d_hold = d;
      if (c == 5 || c == 6) begin
        checks++;
        if (d !== d_hold) begin
          errors++;
          $display("FAIL stall_hold c%0d: got %h expected %h", c, d, d_hold);
        end
      end
      if (out_valid) begin
        checks++;
        if (q.size() == 0 || {bout, ovf, zero, d} !== q[0]) begin
          errors++;
          $display("FAIL stream_data c%0d: got %h expected %h (queued %0d)", c, {bout, ovf, zero, d}, (q.size() > 0) ? q[0] : 35'h0, q.size());
        end
        if (out_ready && q.size() > 0) begin
          void'(q.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_sub(a, b));
        k++;
      end
    end
    in_valid = 0;
    checks++;
    if (got != 6) begin
      errors++;
      $display("FAIL stream_count: got %0d expected 6", got);
    end
  endtask

  task test_reset_mid;
    @(negedge clk);
    out_ready = 0;
    in_valid = 1;
    a = 32'd100;
    b = 32'd1;
    @(negedge clk);
    a = 32'd200;
    b = 32'd2;
    @(negedge clk);
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_fill: got ov=%b in_ready=%b expected 1 0", out_valid, in_ready);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({out_valid, d, bout, ovf, zero} !== 36'h0) begin
      errors++;
      $display("FAIL mid_reset: got ov=%b d=%h f=%b%b%b expected all zero", out_valid, d, bout, ovf, zero);
    end
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    in_valid = 1;
    a = 32'd10;
    b = 32'd4;
    @(negedge clk);
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_stale: got out_valid=%b expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || {bout, ovf, zero, d} !== {3'b000, 32'd6}) begin
      errors++;
      $display("FAIL mid_after: got ov=%b %h expected ov=1 %h", out_valid, {bout, ovf, zero, d}, {3'b000, 32'd6});
    end
  endtask

  task test_random;
    logic [34:0] q [$];
    int sent = 0, got = 0;
    for (int c = 0; c < 5000 && got < 300; c++) begin
      @(negedge clk);
      out_ready = $urandom_range(0, 3) != 0;
      in_valid = sent < 300 && $urandom_range(0, 3) != 0;
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0 || {bout, ovf, zero, d} !== q[0]) begin
          errors++;
          $display("FAIL random_data c%0d: got %h expected %h (queued %0d)", c, {bout, ovf, zero, d}, (q.size() > 0) ? q[0] : 35'h0, q.size());
        end
        if (out_ready && q.size() > 0) begin
          void'(q.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_sub(a, b));
        sent++;
      end
    end
    in_valid = 0;
    checks++;
    if (got != 300) begin
      errors++;
      $display("FAIL random_count: got %0d expected 300", got);
    end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_stream;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
